rtc_bcd_counter: RTL and testbench
==================================

Name: rtc_bcd_counter

Overview:
Stopwatch time base and BCD counter that produces the 24-bit packed BCD count consumed by the seven-segment display decoder. It divides the system clock down to a hundredths-of-a-second tick and counts MM:SS.CC from 00:00.00 to 59:59.99. Start/stop, clear and lap-freeze are controlled by single-cycle pulses from the debounced button logic.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz.
TICK_HZ, 100, count rate in Hz (one LSB of o_count per tick); DIV = CLK_FREQ_HZ/TICK_HZ, must be an integer >= 2.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_start_stop  input  1  single-cycle pulse; toggles run state.
i_clear  input  1  single-cycle pulse; zeroes the count.
i_lap  input  1  single-cycle pulse; toggles lap freeze of the displayed value.
o_count  output  24  packed BCD: [3:0] centisec ones, [7:4] centisec tens, [11:8] sec ones, [15:12] sec tens, [19:16] min ones, [23:20] min tens.
o_running  output  1  1 while counting.
o_lap_active  output  1  1 while o_count is frozen at a lap value.
o_rollover  output  1  one-cycle pulse when count wraps 59:59.99 -> 00:00.00.

Behaviour:
- Reset (i_rst_n low, async): count, lap register, prescaler = 0; o_running = 0, o_lap_active = 0, o_rollover = 0, o_count = 24'h000000. Release is synchronous to i_clk.
- Prescaler: counts 0..DIV-1 only while running; holds value when stopped (stop/start resumes mid-period). Tick asserted in the cycle prescaler == DIV-1 and running; prescaler then returns to 0.
- Count update on tick, same edge: digit limits cs ones 9, cs tens 9, sec ones 9, sec tens 5, min ones 9, min tens 5. Digit at limit wraps to 0 and carries to next digit. Non-BCD digit values (A-F) and tens > 5 are never produced.
- Rollover: tick at 59:59.99 -> 00:00.00, o_rollover high exactly that next cycle, counting continues.
- o_count = lap register when o_lap_active, else live count; both are registers, so o_count changes on the same edge as the tick (zero added latency).
- i_start_stop: toggles o_running on the next edge.
- i_lap: if o_lap_active = 1 -> clear it (display returns to live count). If 0 and o_running = 1 -> capture live count (value after this edge's tick, if any) into lap register, set o_lap_active. If 0 and not running -> ignored.
- i_clear: count, prescaler, lap register -> 0, o_lap_active -> 0; o_running unchanged (clear while running restarts from 00:00.00).
- Priority in one cycle: i_clear overrides tick and i_lap; i_start_stop is still applied alongside i_clear. Tick and i_start_stop together: tick is applied, then run toggles.
- Inputs held high for multiple cycles act on every cycle; pulse shaping is upstream.
- Reset mid-count: all state lost, returns to reset values immediately.

Optional Feature:
RTC_SATURATE_EN: when defined, a tick at 59:59.99 does not wrap. Count holds 59:59.99, o_running drops to 0 the next cycle, o_rollover pulses once. i_start_stop while saturated sets running, but the count stays held until i_clear. When undefined, the count wraps as above and continues.

Test Plan:
- Reset/idle: assert i_rst_n low mid-cycle -> all outputs 0 immediately; 1000 cycles with no pulses -> o_count stays 24'h000000.
- Basic count (CLK_FREQ_HZ=1000, TICK_HZ=100, DIV=10): pulse i_start_stop, run 1000 cycles -> o_count = 24'h000100 (00:01.00), first increment exactly 10 cycles after o_running rises.
- Pause/resume: stop 5 cycles into a period, wait 50, restart -> next increment 5 cycles after restart, no count during the pause.
- Lap: at 00:00.37 pulse i_lap -> o_count holds 24'h000037 for 200 cycles; pulse i_lap -> o_count = 24'h000057.
- Rollover: preload via run to 59:59.99 (or force) -> next tick o_count = 0, o_rollover high 1 cycle. With RTC_SATURATE_EN -> holds 24'h595999, o_running = 0.
- Simultaneous: i_clear and tick same cycle while running -> o_count = 0, o_running stays 1. i_clear + i_start_stop -> o_count = 0, o_running toggles.

Source files
------------

// File: rtl/rtc_bcd_counter.sv
// rtc_bcd_counter: stopwatch prescaler and MM:SS.CC packed BCD counter.
// Define RTC_SATURATE_EN to hold at 59:59.99 instead of wrapping.
module rtc_bcd_counter #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int TICK_HZ     = 100
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start_stop,
   input  logic        i_clear,
   input  logic        i_lap,
   output logic [23:0] o_count,
   output logic        o_running,
   output logic        o_lap_active,
   output logic        o_rollover
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [23:0]   CMAX = 24'h595999;

   logic [PW-1:0] presc_q, presc_d;
   logic [23:0]   cnt_q, cnt_d;
   logic [23:0]   lap_q, lap_d;
   logic          run_q, run_d;
   logic          lapact_q, lapact_d;
   logic          roll_q, roll_d;
   logic          tick;
`ifdef RTC_SATURATE_EN
   logic          sat_q, sat_d;
`endif

   // Each digit wraps at its own limit, which is exactly the digit of CMAX.
   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (r[4*i +: 4] == CMAX[4*i +: 4]) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      tick     = run_q && (presc_q == PMAX);
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      lap_d    = lap_q;
      lapact_d = lapact_q;
      run_d    = run_q;
      roll_d   = 1'b0;
`ifdef RTC_SATURATE_EN
      sat_d    = sat_q;
`endif
      if (run_q) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
`ifdef RTC_SATURATE_EN
         if (cnt_q == CMAX) begin
            if (!sat_q) begin
               roll_d = 1'b1;
               run_d  = 1'b0;
               sat_d  = 1'b1;
            end
         end else begin
            cnt_d = bcd_inc(cnt_q);
         end
`else
         cnt_d  = bcd_inc(cnt_q);
         roll_d = (cnt_q == CMAX);
`endif
      end
      // Lap captures the post-tick value so the frozen display is current.
      if (i_lap) begin
         if (lapact_q) begin
            lapact_d = 1'b0;
         end else if (run_q) begin
            lap_d    = cnt_d;
            lapact_d = 1'b1;
         end
      end
      if (i_clear) begin
         presc_d  = '0;
         cnt_d    = '0;
         lap_d    = '0;
         lapact_d = 1'b0;
         roll_d   = 1'b0;
`ifdef RTC_SATURATE_EN
         sat_d    = 1'b0;
`endif
      end
      run_d = run_d ^ i_start_stop;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         presc_q  <= '0;
         cnt_q    <= '0;
         lap_q    <= '0;
         run_q    <= 1'b0;
         lapact_q <= 1'b0;
         roll_q   <= 1'b0;
`ifdef RTC_SATURATE_EN
         sat_q    <= 1'b0;
`endif
      end else begin
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         lap_q    <= lap_d;
         run_q    <= run_d;
         lapact_q <= lapact_d;
         roll_q   <= roll_d;
`ifdef RTC_SATURATE_EN
         sat_q    <= sat_d;
`endif
      end
   end

   assign o_count      = lapact_q ? lap_q : cnt_q;
   assign o_running    = run_q;
   assign o_lap_active = lapact_q;
   assign o_rollover   = roll_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Directed bench for rtc_bcd_counter at DIV = 10.
// Define RTC_SATURATE_EN to expect holding at 59:59.99.
module tb_rtc_bcd_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ss = 1'b0;
   logic        clr = 1'b0;
   logic        lap = 1'b0;
   logic [23:0] count;
   logic        running;
   logic        lapact;
   logic        roll;
   int          checks = 0;
   int          failures = 0;

   rtc_bcd_counter #(
      .CLK_FREQ_HZ(1000),
      .TICK_HZ    (100)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start_stop(ss),
      .i_clear     (clr),
      .i_lap       (lap),
      .o_count     (count),
      .o_running   (running),
      .o_lap_active(lapact),
      .o_rollover  (roll)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ss();
      ss = 1'b1;
      step();
      ss = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      step();
      lap = 1'b0;
   endtask

   task automatic preload(input logic [23:0] v);
      force dut.cnt_q = v;
      step();
      release dut.cnt_q;
      #1;
   endtask

   task automatic test_reset();
      step(2);
      rst_n = 1'b1;
      step(2);
      pulse_ss();
      step(25);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({count, running, lapact, roll} !== 27'd0) begin
         failures++;
         $display("FAIL reset_async got=%h/%b%b%b exp=000000/000",
                  count, running, lapact, roll);
      end
      step(2);
      rst_n = 1'b1;
      step(1000);
      checks++;
      if (count !== 24'h000000 || running !== 1'b0) begin
         failures++;
         $display("FAIL idle got=%h run=%b exp=000000 run=0", count, running);
      end
   endtask

   task automatic test_basic();
      pulse_ss();
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL start_run got=%b exp=1", running);
      end
      step(9);
      checks++;
      if (count !== 24'h000000) begin
         failures++;
         $display("FAIL first_tick_early got=%h exp=000000", count);
      end
      step(1);
      checks++;
      if (count !== 24'h000001) begin
         failures++;
         $display("FAIL first_tick got=%h exp=000001", count);
      end
      step(990);
      checks++;
      if (count !== 24'h000100) begin
         failures++;
         $display("FAIL one_second got=%h exp=000100", count);
      end
   endtask

   task automatic test_pause();
      step(4);
      pulse_ss();
      checks++;
      if (running !== 1'b0) begin
         failures++;
         $display("FAIL stop_run got=%b exp=0", running);
      end
      step(50);
      checks++;
      if (count !== 24'h000100) begin
         failures++;
         $display("FAIL pause_hold got=%h exp=000100", count);
      end
      pulse_ss();
      step(4);
      checks++;
      if (count !== 24'h000100 || running !== 1'b1) begin
         failures++;
         $display("FAIL resume_early got=%h run=%b exp=000100 run=1",
                  count, running);
      end
      step(1);
      checks++;
      if (count !== 24'h000101) begin
         failures++;
         $display("FAIL resume_tick got=%h exp=000101", count);
      end
   endtask

   task automatic test_lap();
      pulse_clr();
      checks++;
      if (count !== 24'h000000 || running !== 1'b1) begin
         failures++;
         $display("FAIL clear_run got=%h run=%b exp=000000 run=1",
                  count, running);
      end
      step(370);
      checks++;
      if (count !== 24'h000037) begin
         failures++;
         $display("FAIL lap_pre got=%h exp=000037", count);
      end
      pulse_lap();
      checks++;
      if (lapact !== 1'b1 || count !== 24'h000037) begin
         failures++;
         $display("FAIL lap_set got=%h act=%b exp=000037 act=1", count, lapact);
      end
      for (int i = 0; i < 200; i++) begin
         step();
         checks++;
         if (count !== 24'h000037) begin
            failures++;
            $display("FAIL lap_hold cyc=%0d got=%h exp=000037", i, count);
         end
      end
      pulse_lap();
      checks++;
      if (lapact !== 1'b0 || count !== 24'h000057) begin
         failures++;
         $display("FAIL lap_release got=%h act=%b exp=000057 act=0",
                  count, lapact);
      end
      pulse_ss();
      pulse_lap();
      checks++;
      if (lapact !== 1'b0 || count !== 24'h000057) begin
         failures++;
         $display("FAIL lap_stopped got=%h act=%b exp=000057 act=0",
                  count, lapact);
      end
   endtask

   task automatic test_simultaneous();
      pulse_clr();
      pulse_ss();
      step(9);
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (count !== 24'h000000 || running !== 1'b1) begin
         failures++;
         $display("FAIL clear_tick got=%h run=%b exp=000000 run=1",
                  count, running);
      end
      step(9);
      lap = 1'b1;
      step();
      lap = 1'b0;
      checks++;
      if (count !== 24'h000001 || lapact !== 1'b1) begin
         failures++;
         $display("FAIL lap_tick got=%h act=%b exp=000001 act=1", count, lapact);
      end
      pulse_lap();
      step(8);
      ss = 1'b1;
      step();
      ss = 1'b0;
      checks++;
      if (count !== 24'h000002 || running !== 1'b0) begin
         failures++;
         $display("FAIL tick_stop got=%h run=%b exp=000002 run=0",
                  count, running);
      end
      clr = 1'b1;
      ss = 1'b1;
      step();
      checks++;
      if (count !== 24'h000000 || running !== 1'b1) begin
         failures++;
         $display("FAIL clear_start got=%h run=%b exp=000000 run=1",
                  count, running);
      end
      step();
      clr = 1'b0;
      ss = 1'b0;
      checks++;
      if (count !== 24'h000000 || running !== 1'b0) begin
         failures++;
         $display("FAIL clear_stop got=%h run=%b exp=000000 run=0",
                  count, running);
      end
   endtask

   task automatic test_carry();
      logic [23:0] pre [4];
      logic [23:0] post [4];
      pre  = '{24'h000009, 24'h000099, 24'h005999, 24'h095999};
      post = '{24'h000010, 24'h000100, 24'h010000, 24'h100000};
      for (int i = 0; i < 4; i++) begin
         pulse_clr();
         preload(pre[i]);
         pulse_ss();
         step(10);
         checks++;
         if (count !== post[i]) begin
            failures++;
            $display("FAIL carry%0d got=%h exp=%h", i, count, post[i]);
         end
         pulse_ss();
      end
   endtask

   task automatic test_rollover();
      pulse_clr();
      preload(24'h595999);
      pulse_ss();
      step(9);
      checks++;
      if (count !== 24'h595999 || roll !== 1'b0) begin
         failures++;
         $display("FAIL roll_pre got=%h roll=%b exp=595999 roll=0", count, roll);
      end
      step();
`ifdef RTC_SATURATE_EN
      checks++;
      if (count !== 24'h595999 || roll !== 1'b1 || running !== 1'b0) begin
         failures++;
         $display("FAIL sat_hit got=%h roll=%b run=%b exp=595999 roll=1 run=0",
                  count, roll, running);
      end
      step();
      checks++;
      if (roll !== 1'b0) begin
         failures++;
         $display("FAIL sat_pulse got=%b exp=0", roll);
      end
      pulse_ss();
      step(20);
      checks++;
      if (count !== 24'h595999 || running !== 1'b1 || roll !== 1'b0) begin
         failures++;
         $display("FAIL sat_held got=%h run=%b roll=%b exp=595999 run=1 roll=0",
                  count, running, roll);
      end
      pulse_ss();
`else
      checks++;
      if (count !== 24'h000000 || roll !== 1'b1) begin
         failures++;
         $display("FAIL roll_hit got=%h roll=%b exp=000000 roll=1", count, roll);
      end
      step();
      checks++;
      if (roll !== 1'b0 || running !== 1'b1) begin
         failures++;
         $display("FAIL roll_pulse got=%b run=%b exp=0 run=1", roll, running);
      end
      step(9);
      checks++;
      if (count !== 24'h000001) begin
         failures++;
         $display("FAIL roll_continue got=%h exp=000001", count);
      end
      pulse_ss();
`endif
      pulse_clr();
      checks++;
      if (count !== 24'h000000 || running !== 1'b0) begin
         failures++;
         $display("FAIL final_clear got=%h run=%b exp=000000 run=0",
                  count, running);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_lap();
      test_simultaneous();
      test_carry();
      test_rollover();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
